bf_sequencer: RTL and testbench
===============================

Name: bf_sequencer

Overview:
- Top-level controller for the 8x8 Bellman-Ford datapath.
- Sequences one full shortest-path run:
  - clear the datapath;
  - load N_NODES adjacency rows over a valid/ready handshake;
  - run relaxation iterations through the datapath's counter block;
  - stop on datapath finish, iteration limit or watchdog timeout.
- Sits between the host/test interface and the datapath's write_enable, read_enable, iteration_done and rst_global pins.

Parameters:
- N_NODES, 8: rows to load; node count.
- ITER_W, 11: width of the iteration counter, matching the datapath iteration counter.
- MAX_ITER, 7: iteration limit (N_NODES-1); the run ends after this many completed iterations.
- CLEAR_CYCLES, 2: cycles dp_rst_global is held asserted.
- WDOG_W, 10: width of the watchdog counter; timeout is at 2^WDOG_W-1 cycles without rollover.

Ports:
- clk  in  1  system clock, rising edge.
- rst_global  in  1  synchronous, active-low reset of this block.
- start  in  1  run request; sampled only in IDLE, DONE or ERROR.
- load_valid  in  1  host presents an adjacency row on the datapath a_* buses.
- load_ready  out  1  controller accepts a row this cycle.
- dp_rst_global  out  1  datapath reset, active-high.
- dp_write_enable  out  1  to datapath write_enable.
- dp_read_enable  out  1  to datapath read_enable.
- dp_iteration_done  out  1  to datapath iteration_done; single-cycle pulse.
- dp_finish  in  1  from datapath finish.
- dp_rollover  in  1  from datapath rollover_phase_counter; single-cycle pulse, one per iteration.
- dp_pre_rollover  in  1  from datapath pre_rollover_phase_counter.
- busy  out  1  high in CLEAR, LOAD, RUN and ITER_END.
- done  out  1  high in DONE.
- timeout_err  out  1  high in ERROR.
- row_idx  out  3  index of the next row to load (log2 N_NODES bits).
- iter_count  out  ITER_W  completed iterations of the current run.

Behaviour:
- Reset (rst_global low at a rising edge):
  - state goes to IDLE;
  - all outputs 0, except dp_rst_global = 1 while rst_global is low;
  - row_idx, iter_count and the watchdog counter are cleared.
- All outputs are registered, except load_ready and dp_write_enable, which are decoded from state and inputs.
- IDLE:
  - all outputs 0.
  - start=1 -> CLEAR.
- CLEAR:
  - dp_rst_global=1 for exactly CLEAR_CYCLES cycles; row_idx, iter_count and watchdog are cleared.
  - Then -> LOAD.
- LOAD:
  - load_ready=1.
  - dp_write_enable = load_valid & load_ready; it is combinational so it aligns with the host data on the a_* buses.
  - Each accepted row increments row_idx.
  - The accept at row_idx = N_NODES-1 -> RUN next cycle; row_idx wraps to 0.
  - load_valid low: stay in LOAD with no timeout.
- RUN:
  - dp_read_enable=1; the watchdog counter increments each cycle.
  - dp_pre_rollover is informational only; it does not change state.
  - On dp_rollover:
    - iter_count increments; watchdog clears.
    - If dp_finish=1, or iter_count+1 == MAX_ITER -> DONE.
    - Otherwise -> ITER_END.
  - dp_finish=1 without rollover -> DONE; iter_count is unchanged.
  - dp_finish and dp_rollover in the same cycle: iter_count increments and the next state is DONE; finish has priority over ITER_END.
  - Watchdog reaching all-ones -> ERROR.
- ITER_END:
  - dp_iteration_done=1 for one cycle; dp_read_enable stays 1.
  - Then -> RUN.
- DONE:
  - done=1; dp_read_enable=0; iter_count is held for readout.
  - start -> CLEAR.
- ERROR:
  - timeout_err=1 (sticky); dp_read_enable=0.
  - start -> CLEAR; timeout_err clears on leaving ERROR.
- start while busy is ignored.
- iter_count never wraps: MAX_ITER < 2^ITER_W is a configuration requirement.
- rst_global low in any state aborts the run immediately; the datapath is held in reset via dp_rst_global.

Test Plan:
- Reset then start:
  - dp_rst_global high for 2 cycles, then load_ready=1, row_idx=0.
  - Offer 8 rows with load_valid held high -> dp_write_enable high for 8 consecutive cycles; RUN entered on the cycle after the 8th accept.
- Backpressure:
  - Toggle load_valid 1,0,1,0,…
  - dp_write_enable pulses only when load_valid=1; row_idx advances only on accepts; exactly 8 accepts before RUN.
- Iteration limit:
  - dp_rollover every 5 cycles in RUN, dp_finish=0.
  - 6 dp_iteration_done pulses; after the 7th rollover done=1, iter_count=7, dp_read_enable=0.
- Early finish:
  - dp_finish and dp_rollover asserted together on the 3rd rollover.
  - done=1, iter_count=3, and no dp_iteration_done pulse after the 2nd.
- Watchdog:
  - No dp_rollover for 1023 cycles in RUN -> timeout_err=1, dp_read_enable=0.
  - start -> CLEAR, timeout_err=0.
- Mid-run reset:
  - rst_global low during RUN with iter_count=4 -> next cycle IDLE, iter_count=0, busy=0, dp_rst_global=1.
  - start during LOAD is ignored.

Source files
------------

// File: rtl/bf_sequencer.sv
// bf_sequencer: top-level controller for the 8x8 Bellman-Ford datapath.
// Runs one complete shortest-path run. It clears the datapath, loads N_NODES
// adjacency rows over a valid/ready handshake, and then runs relaxation
// iterations. A run ends on datapath finish, on the iteration limit, or on a
// watchdog timeout.
//
// Ports:
//   clk, rst_global      clock (rising edge), synchronous active-low reset
//   start                run request, honoured only in IDLE/DONE/ERROR
//   load_valid/ready     row handshake; the row data travels on the datapath a_* buses
//   dp_rst_global        datapath reset (active-high)
//   dp_write_enable      datapath write strobe, combinational with load_valid
//   dp_read_enable       high while relaxing (RUN and ITER_END)
//   dp_iteration_done    single-cycle pulse between iterations
//   dp_finish            datapath converged
//   dp_rollover          end of one iteration (single-cycle pulse)
//   dp_pre_rollover      informational only
//   busy/done/timeout_err  run status
//   row_idx              next row to load
//   iter_count           completed iterations of the current run
module bf_sequencer #(
  parameter int unsigned N_NODES      = 8,
  parameter int unsigned ITER_W       = 11,
  parameter int unsigned MAX_ITER     = 7,
  parameter int unsigned CLEAR_CYCLES = 2,
  parameter int unsigned WDOG_W       = 10
) (
  input  logic                       clk,
  input  logic                       rst_global,
  input  logic                       start,
  input  logic                       load_valid,
  output logic                       load_ready,
  output logic                       dp_rst_global,
  output logic                       dp_write_enable,
  output logic                       dp_read_enable,
  output logic                       dp_iteration_done,
  input  logic                       dp_finish,
  input  logic                       dp_rollover,
  input  logic                       dp_pre_rollover,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err,
  output logic [$clog2(N_NODES)-1:0] row_idx,
  output logic [ITER_W-1:0]          iter_count
);

  localparam int unsigned ROW_W = $clog2(N_NODES);
  localparam int unsigned CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_ITER_END,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [CLR_W-1:0]    clr_q, clr_d;
  logic [ITER_W-1:0]   iter_inc;
  logic [WDOG_W-1:0]   wdog_inc;

  logic dp_rst_q, rd_en_q, iter_done_q, busy_q, done_q, terr_q;

  // Pre-rollover carries no control meaning here.
  logic pre_rollover_unused;
  assign pre_rollover_unused = dp_pre_rollover;

  assign iter_inc = iter_q + 1'b1;
  assign wdog_inc = wdog_q + 1'b1;

  // The handshake is decoded, not registered, so the write strobe stays in
  // the same cycle as the host data.
  assign load_ready      = (state_q == S_LOAD);
  assign dp_write_enable = load_valid & load_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    iter_d  = iter_q;
    wdog_d  = wdog_q;
    clr_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        row_d  = '0;
        iter_d = '0;
        wdog_d = '0;
        if (clr_q == CLR_W'(CLEAR_CYCLES - 1)) state_d = S_LOAD;
        else                                   clr_d   = clr_q + 1'b1;
      end
      S_LOAD: begin
        if (load_valid) begin
          if (row_q == ROW_W'(N_NODES - 1)) begin
            row_d   = '0;
            state_d = S_RUN;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        // Rollover and finish both take priority over the watchdog. Finish
        // also wins over ITER_END when it arrives with a rollover.
        if (dp_rollover) begin
          iter_d = iter_inc;
          wdog_d = '0;
          if (dp_finish || (iter_inc == ITER_W'(MAX_ITER))) state_d = S_DONE;
          else                                              state_d = S_ITER_END;
        end else if (dp_finish) begin
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_inc;
          if (&wdog_inc) state_d = S_ERROR;
        end
      end
      S_ITER_END: begin
        state_d = S_RUN;
      end
      S_DONE, S_ERROR: begin
        if (start) state_d = S_CLEAR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state, so each one matches
  // the state the FSM occupies in that cycle.
  always_ff @(posedge clk) begin
    if (!rst_global) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      iter_q      <= '0;
      wdog_q      <= '0;
      clr_q       <= '0;
      dp_rst_q    <= 1'b1;
      rd_en_q     <= 1'b0;
      iter_done_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      iter_q      <= iter_d;
      wdog_q      <= wdog_d;
      clr_q       <= clr_d;
      dp_rst_q    <= (state_d == S_CLEAR);
      rd_en_q     <= (state_d == S_RUN) || (state_d == S_ITER_END);
      iter_done_q <= (state_d == S_ITER_END);
      busy_q      <= (state_d == S_CLEAR) || (state_d == S_LOAD) ||
                     (state_d == S_RUN)   || (state_d == S_ITER_END);
      done_q      <= (state_d == S_DONE);
      terr_q      <= (state_d == S_ERROR);
    end
  end

  assign dp_rst_global     = dp_rst_q;
  assign dp_read_enable    = rd_en_q;
  assign dp_iteration_done = iter_done_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign timeout_err       = terr_q;
  assign row_idx           = row_q;
  assign iter_count        = iter_q;

endmodule

// File: tb/tb_bf_sequencer.sv
// tb_bf_sequencer: randomized scoreboard bench for bf_sequencer.
// The stimulus queues the row writes, iteration pulses and run outcome that it
// expects, working them out from the run rules. A negedge monitor pops the
// queues each time the DUT shows one of these events.
`timescale 1ns/1ps
module tb_bf_sequencer;

  localparam int unsigned N_NODES      = 8;
  localparam int unsigned ITER_W       = 11;
  localparam int unsigned MAX_ITER     = 7;
  localparam int unsigned CLEAR_CYCLES = 2;
  localparam int unsigned WDOG_W       = 10;
  localparam int          WDOG_LIMIT   = (1 << WDOG_W) - 1;

  logic clk = 1'b0;
  logic rst_global = 1'b0, start = 1'b0, load_valid = 1'b0;
  logic dp_finish = 1'b0, dp_rollover = 1'b0, dp_pre_rollover = 1'b0;
  logic load_ready, dp_rst_global, dp_write_enable, dp_read_enable, dp_iteration_done;
  logic busy, done, timeout_err;
  logic [2:0]        row_idx;
  logic [ITER_W-1:0] iter_count;

  bf_sequencer #(
    .N_NODES(N_NODES), .ITER_W(ITER_W), .MAX_ITER(MAX_ITER),
    .CLEAR_CYCLES(CLEAR_CYCLES), .WDOG_W(WDOG_W)
  ) dut (
    .clk(clk), .rst_global(rst_global), .start(start),
    .load_valid(load_valid), .load_ready(load_ready),
    .dp_rst_global(dp_rst_global), .dp_write_enable(dp_write_enable),
    .dp_read_enable(dp_read_enable), .dp_iteration_done(dp_iteration_done),
    .dp_finish(dp_finish), .dp_rollover(dp_rollover), .dp_pre_rollover(dp_pre_rollover),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .row_idx(row_idx), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { bit is_err; int iters; } end_t;
  int   wr_q[$];
  int   it_q[$];
  end_t end_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input int val);
    checks++;
    errors++;
    $display("FAIL %s: DUT event with nothing expected (value %0d) at %0t", name, val, $time);
  endtask

  // Monitor
  logic done_prev = 1'b0, terr_prev = 1'b0;
  always @(negedge clk) begin
    int   exp_row, exp_it;
    end_t e;
    if (rst_global) begin
      if (dp_write_enable) begin
        if (wr_q.size() == 0) unexpected("write_enable", int'(row_idx));
        else begin
          exp_row = wr_q.pop_front();
          check("write_row_idx", 32'(row_idx), 32'(exp_row));
          check("write_needs_valid", 32'(load_valid), 32'd1);
        end
      end
      if (dp_iteration_done) begin
        if (it_q.size() == 0) unexpected("iteration_done", int'(iter_count));
        else begin
          exp_it = it_q.pop_front();
          check("iter_done_count", 32'(iter_count), 32'(exp_it));
          check("iter_done_read_en", 32'(dp_read_enable), 32'd1);
        end
      end
      if ((done && !done_prev) || (timeout_err && !terr_prev)) begin
        if (end_q.size() == 0) unexpected("run_end", int'(iter_count));
        else begin
          e = end_q.pop_front();
          check("end_kind", 32'({timeout_err, done}), e.is_err ? 32'd2 : 32'd1);
          check("end_iter_count", 32'(iter_count), 32'(e.iters));
          check("end_read_en", 32'(dp_read_enable), 32'd0);
        end
      end
    end
    done_prev <= done;
    terr_prev <= timeout_err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_global = 1'b0; start = 1'b0; load_valid = 1'b0;
    dp_finish = 1'b0; dp_rollover = 1'b0; dp_pre_rollover = 1'b0;
    repeat (3) tick();
    check("reset_outputs",
          32'({dp_rst_global, busy, done, timeout_err, load_ready, dp_write_enable,
               dp_read_enable, dp_iteration_done}), 32'h80);
    check("reset_row_iter", 32'({row_idx, iter_count}), 32'd0);
    rst_global = 1'b1;
    tick();
    check("idle_outputs",
          32'({dp_rst_global, busy, done, timeout_err, load_ready, dp_write_enable,
               dp_read_enable, dp_iteration_done}), 32'h00);
  endtask

  task automatic start_run();
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_clears_status", 32'({done, timeout_err, busy}), 32'd1);
    n = 0;
    while (dp_rst_global && n < 20) begin
      n++;
      tick();
    end
    check("clear_cycles", 32'(n), 32'(CLEAR_CYCLES));
    check("load_entry", 32'({load_ready, busy, row_idx, iter_count}), 32'({2'b11, 3'd0, 11'd0}));
  endtask

  // mode 0: valid held high, 1: alternating 1/0, 2: random idle gaps
  task automatic load_rows(input int mode, input bit poke_start);
    int idle;
    for (int i = 0; i < int'(N_NODES); i++) begin
      idle = (i == 0) ? 0 : (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int k = 0; k < idle; k++) begin
        load_valid = 1'b0;
        if (poke_start && i == 3) start = 1'b1;
        tick();
        start = 1'b0;
        if (poke_start && i == 3)
          check("start_ignored_in_load", 32'({busy, load_ready, dp_rst_global}), 32'd6);
      end
      load_valid = 1'b1;
      wr_q.push_back(i);
      tick();
    end
    load_valid = 1'b0;
    check("run_entered", 32'({dp_read_enable, load_ready, row_idx}), 32'({1'b1, 1'b0, 3'd0}));
  endtask

  // Starts in the first RUN cycle. It drives `rolls` rollovers, each after a
  // random gap of RUN cycles. Finish is optionally raised with the last
  // rollover, or on its own after the rollovers.
  task automatic run_iters(input int rolls, input bit fin_on_last, input bit fin_after,
                           input int gmin, input int gmax);
    int  g;
    bit  fin, ended;
    end_t e;
    ended = 1'b0;
    for (int k = 1; k <= rolls && !ended; k++) begin
      g = int'($urandom_range(gmin, gmax));
      for (int c = 1; c < g; c++) begin
        dp_pre_rollover = 1'($urandom_range(0, 1));
        tick();
      end
      dp_pre_rollover = 1'b0;
      fin = fin_on_last && (k == rolls);
      // Every rollover completes an iteration. The run ends on finish or on
      // the limit; every other iteration is followed by one done pulse.
      if (fin || k == int'(MAX_ITER)) begin
        ended = 1'b1;
        e.is_err = 1'b0; e.iters = k;
        end_q.push_back(e);
      end else begin
        it_q.push_back(k);
      end
      dp_rollover = 1'b1; dp_finish = fin;
      tick();
      dp_rollover = 1'b0; dp_finish = 1'b0;
      if (!ended) tick();
    end
    if (!ended && fin_after) begin
      g = int'($urandom_range(gmin, gmax));
      for (int c = 1; c < g; c++) tick();
      e.is_err = 1'b0; e.iters = rolls;
      end_q.push_back(e);
      ended = 1'b1;
      dp_finish = 1'b1;
      tick();
      dp_finish = 1'b0;
    end
    if (ended) check("done_after_end", 32'({done, busy, dp_read_enable}), 32'd4);
  endtask

  task automatic watchdog_run();
    int   n;
    end_t e;
    e.is_err = 1'b1; e.iters = 0;
    end_q.push_back(e);
    n = 0;
    while (!timeout_err && n < WDOG_LIMIT + 50) begin
      tick();
      n++;
    end
    check("watchdog_cycles", 32'(n), 32'(WDOG_LIMIT));
    tick();
    check("error_sticky", 32'({timeout_err, busy, dp_read_enable}), 32'd4);
  endtask

  initial begin
    #3ms;
    $display("FAIL global_timeout: simulation did not complete at %0t", $time);
    $fatal(1);
  end

  initial begin
    int kind, rolls;
    do_reset();

    // Solid load followed by the iteration limit, rollover every 5 cycles
    start_run(); load_rows(0, 1'b0); run_iters(int'(MAX_ITER), 1'b0, 1'b0, 5, 5);
    // Backpressure and start during LOAD, then finish with the 3rd rollover
    start_run(); load_rows(1, 1'b1); run_iters(3, 1'b1, 1'b0, 1, 8);
    // Finish without a rollover after 2 iterations
    start_run(); load_rows(2, 1'b0); run_iters(2, 1'b0, 1'b1, 1, 8);
    // Watchdog timeout, followed by a restart from ERROR
    start_run(); load_rows(2, 1'b0); watchdog_run();
    // Long gaps just below the watchdog limit: the watchdog must clear on rollover
    start_run(); load_rows(0, 1'b0); run_iters(int'(MAX_ITER), 1'b0, 1'b0, 1000, 1020);

    for (int r = 0; r < 8; r++) begin
      kind = int'($urandom_range(0, 2));
      start_run();
      load_rows(int'($urandom_range(0, 2)), 1'b0);
      case (kind)
        0: run_iters(int'(MAX_ITER), 1'b0, 1'b0, 1, 8);
        1: begin rolls = int'($urandom_range(1, MAX_ITER)); run_iters(rolls, 1'b1, 1'b0, 1, 8); end
        default: begin rolls = int'($urandom_range(0, MAX_ITER - 1)); run_iters(rolls, 1'b0, 1'b1, 1, 8); end
      endcase
    end

    // Reset in the middle of a run
    start_run(); load_rows(0, 1'b0); run_iters(4, 1'b0, 1'b0, 2, 6);
    check("pre_abort_iter", 32'({iter_count, dp_read_enable}), 32'({11'd4, 1'b1}));
    rst_global = 1'b0;
    tick();
    check("abort_outputs", 32'({busy, dp_rst_global, dp_read_enable, done, iter_count}),
          32'({4'b0100, 11'd0}));
    rst_global = 1'b1;
    tick();
    check("abort_release", 32'({busy, dp_rst_global, row_idx}), 32'd0);
    start_run(); load_rows(2, 1'b0); run_iters(int'(MAX_ITER), 1'b0, 1'b0, 1, 3);

    repeat (3) tick();
    check("writes_outstanding", 32'(wr_q.size()), 32'd0);
    check("iter_pulses_outstanding", 32'(it_q.size()), 32'd0);
    check("run_ends_outstanding", 32'(end_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
